// File: rtl/ram32_pkg.sv
// Shared types, constants and the byte-merge helper for the 32-bit RAM
// read-modify-write controller.
package ram32_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RMW_WR  = 2'd2,
        RSP     = 2'd3
    } ram32_state_e;

    localparam logic [3:0] WSTRB_FULL = 4'hF;

    // Bytes whose strobe is set come from new_word, the rest from old_word.
    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  strb
    );
        logic [31:0] mask;
        for (int i = 0; i < 4; i++) begin
            mask[8*i +: 8] = {8{strb[i]}};
        end
        return (new_word & mask) | (old_word & ~mask);
    endfunction

endpackage

// File: rtl/ram32_rmw_ctrl.sv
// Request/response front end for a 32-bit synchronous RAM that turns
// byte-strobed writes into read-modify-write sequences.
module ram32_rmw_ctrl
    import ram32_pkg::*;
#(
    parameter  int RAM_SIZE  = 1024,
    localparam int ADDR_BITS = $clog2(RAM_SIZE / 4)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic                 req_we,
    input  logic [31:0]          req_wdata,
    input  logic [3:0]           req_wstrb,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_rdata,
    output logic [ADDR_BITS-1:0] ram_addr,
    output logic                 ram_we,
    output logic [31:0]          ram_wdata,
    input  logic [31:0]          ram_rdata
);

    ram32_state_e         state_r;
    logic [ADDR_BITS-1:0] addr_r;
    logic [31:0]          wdata_r;
    logic [3:0]           wstrb_r;
    logic                 is_partial_r;
    logic [31:0]          merged_r;
    logic [31:0]          rsp_rdata_r;

    logic                 accept_s;
    logic                 full_wr_s;
    logic                 partial_wr_s;

    assign req_ready = (state_r == IDLE) && !reset;
    assign rsp_valid = (state_r == RSP) && !reset;
    assign rsp_rdata = rsp_rdata_r;

    // Classify the request presented in the current cycle.
    always_comb begin
        accept_s     = (state_r == IDLE) && req_valid && !reset;
        full_wr_s    = req_we && (req_wstrb == WSTRB_FULL);
        partial_wr_s = req_we && (req_wstrb != 4'h0) && (req_wstrb != WSTRB_FULL);
    end

    // RAM port: the accept cycle addresses the RAM directly from the request
    // so the read (or full write) starts without an extra cycle.
    always_comb begin
        ram_addr  = addr_r;
        ram_we    = 1'b0;
        ram_wdata = 32'h0000_0000;
        if (accept_s) begin
            ram_addr = req_addr;
            if (full_wr_s) begin
                ram_we    = 1'b1;
                ram_wdata = req_wdata;
            end else begin
                ram_we    = 1'b0;
                ram_wdata = 32'h0000_0000;
            end
        end else if ((state_r == RMW_WR) && !reset) begin
            ram_we    = 1'b1;
            ram_wdata = merged_r;
        end else begin
            ram_we    = 1'b0;
            ram_wdata = 32'h0000_0000;
        end
    end

    // Transaction sequencer with latched request fields and response data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            addr_r       <= '0;
            wdata_r      <= 32'h0000_0000;
            wstrb_r      <= 4'h0;
            is_partial_r <= 1'b0;
            merged_r     <= 32'h0000_0000;
            rsp_rdata_r  <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        addr_r       <= req_addr;
                        wdata_r      <= req_wdata;
                        wstrb_r      <= req_wstrb;
                        is_partial_r <= partial_wr_s;
                        if (full_wr_s) begin
                            rsp_rdata_r <= req_wdata;
                            state_r     <= RSP;
                        end else begin
                            state_r <= RD_WAIT;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RD_WAIT: begin
                    if (is_partial_r) begin
                        merged_r <= merge_bytes(ram_rdata, wdata_r, wstrb_r);
                        state_r  <= RMW_WR;
                    end else begin
                        rsp_rdata_r <= ram_rdata;
                        state_r     <= RSP;
                    end
                end
                RMW_WR: begin
                    rsp_rdata_r <= merged_r;
                    state_r     <= RSP;
                end
                RSP: begin
                    if (rsp_ready) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= RSP;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ram32_rmw_ctrl.md
RAM32_RMW_CTRL -- requirements
Module: ram32_rmw_ctrl

Interface
REQ-001 Parameter: RAM_SIZE, default 1024, RAM size in bytes.
REQ-002 Derived constant: ADDR_BITS = $clog2(RAM_SIZE/4); it is not overridable.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  1  request present.
REQ-006 req_ready  out  1  request accepted when high together with req_valid.
REQ-007 req_addr  in  ADDR_BITS  word address.
REQ-008 req_we  in  1  1 = write, 0 = read.
REQ-009 req_wdata  in  32  write data.
REQ-010 req_wstrb  in  4  byte enables; bit i covers bits [8i+7:8i].
REQ-011 rsp_valid  out  1  response present.
REQ-012 rsp_ready  in  1  response consumed when high together with rsp_valid.
REQ-013 rsp_rdata  out  32  read data, or the final written word for writes.
REQ-014 ram_addr  out  ADDR_BITS  RAM word address.
REQ-015 ram_we  out  1  RAM write enable.
REQ-016 ram_wdata  out  32  RAM write data.
REQ-017 ram_rdata  in  32  RAM registered output.
- The RAM returns mem[addr] one cycle after the address is presented.
- When we is high, the RAM returns the written data instead.

Function
REQ-018 States: IDLE, RD_WAIT, RMW_WR, RSP.
- req_ready = 1 only in IDLE and only while reset = 0.
REQ-019 Accept cycle: the cycle in IDLE with req_valid & req_ready.
- ram_addr = req_addr combinationally in that cycle.
- In all other states, ram_addr = the latched address.
REQ-020 Read, or write with wstrb = 4'h0 (treated as a read, no RAM write):
- In the accept cycle, ram_we = 0; next state is RD_WAIT.
- In RD_WAIT, capture ram_rdata into rsp_rdata; next state is RSP.
REQ-021 Full write (wstrb = 4'hF):
- In the accept cycle, ram_we = 1 and ram_wdata = req_wdata.
- rsp_rdata <= req_wdata; next state is RSP.
REQ-022 Partial write (wstrb not 0 and not F):
- In the accept cycle, perform a read (ram_we = 0).
- In RD_WAIT, merge: bytes with strobe = 1 come from the latched wdata, all others from ram_rdata.
- Store the merged word; next state is RMW_WR.
REQ-023 RMW_WR: ram_we = 1 and ram_wdata = merged word; rsp_rdata <= merged word; next state is RSP.
REQ-024 RSP: rsp_valid = 1.
- rsp_rdata stays stable while rsp_valid & !rsp_ready.
- The transition to IDLE happens on rsp_ready.
- No new request is accepted in the RSP cycle.
REQ-025 Latency, measured from accept cycle N to first rsp_valid:
- read: N+2
- full write: N+1
- partial write: N+3
REQ-026 ram_we is high only in the full-write accept cycle and in RMW_WR; it is 0 in every other cycle.
REQ-027 ram_wdata = 0 whenever ram_we = 0.
REQ-028 Request fields are latched at accept; later changes on the req_* inputs have no effect on the transaction in flight.
REQ-029 Words outside the byte-merge path are never written.

Reset
REQ-030 While reset = 1: state <= IDLE, rsp_valid = 0, rsp_rdata <= 0, latched registers <= 0, req_ready = 0, ram_we = 0.
REQ-031 Reset asserted mid-transaction, including in RMW_WR, aborts the transaction.
- No RAM write occurs in that cycle.
- No response is produced.
REQ-032 First request acceptance is possible in the first cycle after reset deasserts.

Structure
REQ-033 Package ram32_pkg holds the following; the module imports ram32_pkg:
- the state enum type;
- the constant WSTRB_FULL = 4'hF;
- the function merge_bytes(old, new, strb).
REQ-034 No sub-module is used.
- The bench connects ram_* to an external 32-bit synchronous RAM with write-through read data and one-cycle read latency.

Verification
REQ-035 Write 0xDEADBEEF with wstrb F to addr 5, then read addr 5 -> write rsp_rdata = 0xDEADBEEF at N+1; read rsp_rdata = 0xDEADBEEF at N+2.
REQ-036 Preload 0x11223344 at addr 7; write 0xAABBCCDD with wstrb 4'b0101 -> exactly one ram_we pulse, at N+2; rsp_rdata and the memory word both = 0x11BB33DD.
REQ-037 Write with wstrb 0 to an address holding 0xCAFEF00D -> no ram_we pulse; rsp_rdata = 0xCAFEF00D.
REQ-038 Hold rsp_ready = 0 for 5 cycles during a read -> rsp_valid and rsp_rdata stable; req_ready = 0 throughout; IDLE reached the cycle after rsp_ready = 1.
REQ-039 Assert reset during RMW_WR of a partial write -> memory word unchanged, rsp_valid stays 0, req_ready = 1 in the first cycle after reset deasserts.
